// File: rtl/gpio_irq_regfile_if.sv
// Register access bus between the AXI slave front end and the GPIO register block.
//   reg_addr  : byte address, [7:2] decoded by the slave
//   reg_wdata : write data
//   reg_we    : write strobe, one cycle per access
//   reg_re    : read strobe, one cycle per access
//   reg_wstrb : byte enables for writes
//   reg_rdata : read data, valid the cycle after reg_re
interface gpio_reg_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [31:0]           reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [3:0]            reg_wstrb;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re, reg_wstrb,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re, reg_wstrb,
    output reg_rdata
  );
endinterface

// File: rtl/gpio_irq_regfile.sv
// GPIO register block: per-pin direction, atomic SET/CLR/TGL of outputs,
// synchronised + debounced inputs, rise/fall edge interrupts with W1C status.
//   clk, rstn : clock, async active-low reset
//   bus       : register access bus (slave side), 1-cycle registered read
//   gpio_in   : async pin inputs
//   gpio_out  : output values (DATA_OUT)
//   gpio_dir  : 1 = output, 0 = input (DIR)
//   irq       : |(IRQ_STATUS & IRQ_EN), registered
module gpio_irq_regfile #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_PINS    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 8
) (
  input  logic        clk,
  input  logic        rstn,
  gpio_reg_if.slave   bus,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_dir,
  output logic        irq
);

  localparam int unsigned PW = 32;
  localparam logic [PW-1:0] PIN_MASK = PW'((64'd1 << NUM_PINS) - 64'd1);

  localparam logic [5:0] A_DATA_OUT = 6'd0;
  localparam logic [5:0] A_DIR      = 6'd1;
  localparam logic [5:0] A_DATA_IN  = 6'd2;
  localparam logic [5:0] A_OUT_SET  = 6'd3;
  localparam logic [5:0] A_OUT_CLR  = 6'd4;
  localparam logic [5:0] A_OUT_TGL  = 6'd5;
  localparam logic [5:0] A_IRQ_EN   = 6'd6;
  localparam logic [5:0] A_IRQ_RISE = 6'd7;
  localparam logic [5:0] A_IRQ_FALL = 6'd8;
  localparam logic [5:0] A_IRQ_STAT = 6'd9;
  localparam logic [5:0] A_DEBOUNCE = 6'd10;

  logic [PW-1:0]         data_out_q, dir_q, en_q, rise_q, fall_q, status_q;
  logic [PW-1:0]         data_out_d, dir_d, en_d, rise_d, fall_d, status_d;
  logic [DEBOUNCE_W-1:0] deb_q, deb_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  irq_q;

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         stable_q, stable_dly_q;
  logic [DEBOUNCE_W-1:0] cnt_q [PW];

  logic [5:0]    widx_c;
  logic [PW-1:0] bmask_c, wmask_c, wbits_c, w1c_c, set_c, s_c, rdata_c;
  logic          deb_wr_c;
  logic          unused_addr_bits;

  assign widx_c  = bus.reg_addr[7:2];
  assign bmask_c = {{8{bus.reg_wstrb[3]}}, {8{bus.reg_wstrb[2]}},
                    {8{bus.reg_wstrb[1]}}, {8{bus.reg_wstrb[0]}}};
  assign wmask_c = bmask_c & PIN_MASK;
  assign wbits_c = PW'(bus.reg_wdata) & wmask_c;
  assign unused_addr_bits = ^{bus.reg_addr[31:8], bus.reg_addr[1:0]};

  // Synchronised input; unimplemented pins forced to 0 so they never count
  assign s_c = sync_q[SYNC_STAGES-1] & PIN_MASK;

  // Edge events on the debounced value
  assign set_c = ((stable_q & ~stable_dly_q & rise_q) |
                  (~stable_q & stable_dly_q & fall_q)) & PIN_MASK;

  // Register write decode; strobed bytes only
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    en_d       = en_q;
    rise_d     = rise_q;
    fall_d     = fall_q;
    deb_d      = deb_q;
    deb_wr_c   = 1'b0;
    w1c_c      = '0;
    if (bus.reg_we) begin
      case (widx_c)
        A_DATA_OUT: data_out_d = (data_out_q & ~wmask_c) | wbits_c;
        A_DIR:      dir_d      = (dir_q & ~wmask_c) | wbits_c;
        A_OUT_SET:  data_out_d = data_out_q | wbits_c;
        A_OUT_CLR:  data_out_d = data_out_q & ~wbits_c;
        A_OUT_TGL:  data_out_d = data_out_q ^ wbits_c;
        A_IRQ_EN:   en_d       = (en_q & ~wmask_c) | wbits_c;
        A_IRQ_RISE: rise_d     = (rise_q & ~wmask_c) | wbits_c;
        A_IRQ_FALL: fall_d     = (fall_q & ~wmask_c) | wbits_c;
        A_IRQ_STAT: w1c_c      = wbits_c;
        A_DEBOUNCE: begin
          deb_d    = DEBOUNCE_W'((PW'(deb_q) & ~bmask_c) | (PW'(bus.reg_wdata) & bmask_c));
          deb_wr_c = 1'b1;
        end
        default: ;
      endcase
    end
    // A set event in the same cycle as W1C wins
    status_d = (status_q & ~w1c_c) | set_c;
  end

  // Read mux on pre-write values
  always_comb begin
    rdata_c = '0;
    case (widx_c)
      A_DATA_OUT: rdata_c = data_out_q;
      A_DIR:      rdata_c = dir_q;
      A_DATA_IN:  rdata_c = stable_q;
      A_IRQ_EN:   rdata_c = en_q;
      A_IRQ_RISE: rdata_c = rise_q;
      A_IRQ_FALL: rdata_c = fall_q;
      A_IRQ_STAT: rdata_c = status_q;
      A_DEBOUNCE: rdata_c = PW'(deb_q);
      default:    rdata_c = '0;
    endcase
  end

  // Control/status registers, read data and irq
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_q <= '0;
      dir_q      <= '0;
      en_q       <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      status_q   <= '0;
      deb_q      <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      status_q   <= status_d;
      deb_q      <= deb_d;
      irq_q      <= |(status_d & en_d);
      if (bus.reg_re) rdata_q <= DATA_WIDTH'(rdata_c);
    end
  end

  // Input synchroniser
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Per-pin debounce: accept a new level after DEBOUNCE+1 consecutive differing cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < int'(PW); i++) cnt_q[i] <= '0;
    end else begin
      stable_dly_q <= stable_q;
      for (int i = 0; i < int'(PW); i++) begin
        if (s_c[i] != stable_q[i]) begin
          if (cnt_q[i] == deb_q) begin
            stable_q[i] <= s_c[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + DEBOUNCE_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
        if (deb_wr_c) cnt_q[i] <= '0;
      end
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign gpio_out      = data_out_q;
  assign gpio_dir      = dir_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_irq_regfile.sv
// Bench for gpio_irq_regfile: directed register traffic on a 32-pin and an
// 8-pin instance; reads are scoreboarded and checked by a separate monitor.
module tb_gpio_irq_regfile;

  localparam logic [31:0] A_DATA_OUT = 32'h00;
  localparam logic [31:0] A_DIR      = 32'h04;
  localparam logic [31:0] A_DATA_IN  = 32'h08;
  localparam logic [31:0] A_SET      = 32'h0C;
  localparam logic [31:0] A_CLR      = 32'h10;
  localparam logic [31:0] A_TGL      = 32'h14;
  localparam logic [31:0] A_EN       = 32'h18;
  localparam logic [31:0] A_RISE     = 32'h1C;
  localparam logic [31:0] A_FALL     = 32'h20;
  localparam logic [31:0] A_STAT     = 32'h24;
  localparam logic [31:0] A_DEB      = 32'h28;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out32, gpio_dir32, gpio_out8, gpio_dir8;
  logic        irq32, irq8;

  always #5 clk = ~clk;

  gpio_reg_if #(.DATA_WIDTH(32)) bus32 ();
  gpio_reg_if #(.DATA_WIDTH(32)) bus8 ();

  gpio_irq_regfile u_dut32 (
    .clk(clk), .rstn(rstn), .bus(bus32), .gpio_in(gpio_in),
    .gpio_out(gpio_out32), .gpio_dir(gpio_dir32), .irq(irq32)
  );

  gpio_irq_regfile #(.NUM_PINS(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .bus(bus8), .gpio_in(gpio_in),
    .gpio_out(gpio_out8), .gpio_dir(gpio_dir8), .irq(irq8)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q32[$], addr_q32[$], exp_q8[$], addr_q8[$];
  logic        rv32, rv8;
  logic [31:0] mon_e, mon_a;

  // Read-valid tracking: rdata is presented the cycle after reg_re
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rv32 <= 1'b0;
      rv8  <= 1'b0;
    end else begin
      rv32 <= bus32.reg_re;
      rv8  <= bus8.reg_re;
    end
  end

  // Monitor: pop expected read data and compare
  always @(negedge clk) begin
    if (rv32) begin
      n_checks++;
      if (exp_q32.size() == 0) begin
        n_fail++;
        $display("FAIL rd32 unexpected read got=%h", bus32.reg_rdata);
      end else begin
        mon_e = exp_q32.pop_front();
        mon_a = addr_q32.pop_front();
        if (bus32.reg_rdata !== mon_e) begin
          n_fail++;
          $display("FAIL rd32 addr=%h got=%h exp=%h", mon_a, bus32.reg_rdata, mon_e);
        end
      end
    end
    if (rv8) begin
      n_checks++;
      if (exp_q8.size() == 0) begin
        n_fail++;
        $display("FAIL rd8 unexpected read got=%h", bus8.reg_rdata);
      end else begin
        mon_e = exp_q8.pop_front();
        mon_a = addr_q8.pop_front();
        if (bus8.reg_rdata !== mon_e) begin
          n_fail++;
          $display("FAIL rd8 addr=%h got=%h exp=%h", mon_a, bus8.reg_rdata, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus32.reg_addr = a; bus32.reg_wdata = d; bus32.reg_wstrb = s; bus32.reg_we = 1'b1;
    @(posedge clk); #1;
    bus32.reg_we = 1'b0;
  endtask

  task automatic rd32(input logic [31:0] a, input logic [31:0] e);
    bus32.reg_addr = a; bus32.reg_re = 1'b1;
    exp_q32.push_back(e); addr_q32.push_back(a);
    @(posedge clk); #1;
    bus32.reg_re = 1'b0;
  endtask

  task automatic wrrd32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] e);
    bus32.reg_addr = a; bus32.reg_wdata = d; bus32.reg_wstrb = s;
    bus32.reg_we = 1'b1; bus32.reg_re = 1'b1;
    exp_q32.push_back(e); addr_q32.push_back(a);
    @(posedge clk); #1;
    bus32.reg_we = 1'b0; bus32.reg_re = 1'b0;
  endtask

  task automatic wr8(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus8.reg_addr = a; bus8.reg_wdata = d; bus8.reg_wstrb = s; bus8.reg_we = 1'b1;
    @(posedge clk); #1;
    bus8.reg_we = 1'b0;
  endtask

  task automatic rd8(input logic [31:0] a, input logic [31:0] e);
    bus8.reg_addr = a; bus8.reg_re = 1'b1;
    exp_q8.push_back(e); addr_q8.push_back(a);
    @(posedge clk); #1;
    bus8.reg_re = 1'b0;
  endtask

  initial begin
    logic [31:0] addrs [11];
    addrs = '{A_DATA_OUT, A_DIR, A_DATA_IN, A_SET, A_CLR, A_TGL,
              A_EN, A_RISE, A_FALL, A_STAT, A_DEB};

    rstn = 1'b0;
    gpio_in = '0;
    bus32.reg_addr = '0; bus32.reg_wdata = '0; bus32.reg_we = 1'b0;
    bus32.reg_re = 1'b0; bus32.reg_wstrb = '0;
    bus8.reg_addr = '0; bus8.reg_wdata = '0; bus8.reg_we = 1'b0;
    bus8.reg_re = 1'b0; bus8.reg_wstrb = '0;
    #12 rstn = 1'b1;
    @(posedge clk); #1;

    // Reset state: every register reads 0, outputs low
    foreach (addrs[i]) rd32(addrs[i], 32'h0);
    rd32(32'h2C, 32'h0);
    chk("reset irq", 32'(irq32), 32'h0);
    chk("reset gpio_out", gpio_out32, 32'h0);
    chk("reset gpio_dir", gpio_dir32, 32'h0);

    // Atomic set/clear/toggle with byte strobes
    wr32(A_DATA_OUT, 32'h0000_00F0, 4'hF);
    wr32(A_SET, 32'h0000_000F, 4'hF);
    wr32(A_CLR, 32'h0000_0030, 4'hF);
    wr32(A_TGL, 32'h0000_0101, 4'h1);
    rd32(A_DATA_OUT, 32'h0000_00CE);
    chk("gpio_out after set/clr/tgl", gpio_out32, 32'h0000_00CE);
    rd32(A_SET, 32'h0);
    rd32(A_TGL, 32'h0);
    wrrd32(A_DATA_OUT, 32'hAABB_CCDD, 4'b0100, 32'h0000_00CE);
    rd32(A_DATA_OUT, 32'h00BB_00CE);
    wr32(A_DIR, 32'h0000_00A5, 4'hF);
    chk("gpio_dir", gpio_dir32, 32'h0000_00A5);
    rd32(A_DIR, 32'h0000_00A5);
    wr32(A_DATA_IN, 32'hFFFF_FFFF, 4'hF);
    rd32(A_DATA_IN, 32'h0);
    wr32(32'h30, 32'hFFFF_FFFF, 4'hF);
    rd32(32'h30, 32'h0);

    // Rise interrupt with DEBOUNCE = 0: DATA_IN after 3 edges, irq on the 4th
    wr32(A_DEB, 32'h0, 4'hF);
    wr32(A_RISE, 32'h1, 4'hF);
    wr32(A_EN, 32'h1, 4'hF);
    chk("irq idle", 32'(irq32), 32'h0);
    gpio_in[0] = 1'b1;
    rd32(A_DATA_IN, 32'h0);
    rd32(A_DATA_IN, 32'h0);
    rd32(A_DATA_IN, 32'h0);
    chk("irq before status", 32'(irq32), 32'h0);
    rd32(A_DATA_IN, 32'h1);
    chk("irq on rise", 32'(irq32), 32'h1);
    rd32(A_STAT, 32'h1);
    wr32(A_STAT, 32'h1, 4'hF);
    chk("irq after w1c", 32'(irq32), 32'h0);
    rd32(A_STAT, 32'h0);

    // DEBOUNCE = 4: 4-cycle glitch rejected, 5-cycle pulse accepted after 7 edges
    wr32(A_RISE, 32'h9, 4'hF);
    wr32(A_FALL, 32'h4, 4'hF);
    wr32(A_DEB, 32'h4, 4'hF);
    rd32(A_DEB, 32'h4);
    gpio_in[3] = 1'b1;
    idle(4);
    gpio_in[3] = 1'b0;
    idle(10);
    rd32(A_DATA_IN, 32'h1);
    rd32(A_STAT, 32'h0);
    gpio_in[3] = 1'b1;
    repeat (5) rd32(A_DATA_IN, 32'h1);
    gpio_in[3] = 1'b0;
    rd32(A_DATA_IN, 32'h1);
    rd32(A_DATA_IN, 32'h1);
    rd32(A_DATA_IN, 32'h9);
    rd32(A_STAT, 32'h8);
    chk("irq pin3 not enabled", 32'(irq32), 32'h0);
    idle(8);
    rd32(A_DATA_IN, 32'h1);
    rd32(A_STAT, 32'h8);
    wr32(A_STAT, 32'h8, 4'hF);
    rd32(A_STAT, 32'h0);

    // Fall event on pin 2 coinciding with W1C: status bit survives
    wr32(A_DEB, 32'h0, 4'hF);
    wr32(A_RISE, 32'hD, 4'hF);
    gpio_in[2] = 1'b1;
    idle(5);
    rd32(A_STAT, 32'h4);
    gpio_in[2] = 1'b0;
    idle(3);
    wr32(A_STAT, 32'h4, 4'hF);
    rd32(A_STAT, 32'h4);
    wr32(A_EN, 32'h5, 4'hF);
    chk("irq on enable", 32'(irq32), 32'h1);

    // 8-pin instance masks upper bits
    wr8(A_DIR, 32'hFFFF_FFFF, 4'hF);
    rd8(A_DIR, 32'h0000_00FF);
    chk("gpio_dir8", gpio_dir8, 32'h0000_00FF);
    wr8(A_DATA_OUT, 32'hFFFF_FFFF, 4'hF);
    chk("gpio_out8", gpio_out8, 32'h0000_00FF);

    // Asynchronous reset mid-debounce clears everything at once
    wr32(A_DEB, 32'h8, 4'hF);
    gpio_in[5] = 1'b1;
    idle(4);
    rstn = 1'b0;
    #1;
    chk("async rst gpio_out32", gpio_out32, 32'h0);
    chk("async rst gpio_dir32", gpio_dir32, 32'h0);
    chk("async rst irq32", 32'(irq32), 32'h0);
    chk("async rst rdata32", bus32.reg_rdata, 32'h0);
    chk("async rst gpio_out8", gpio_out8, 32'h0);
    chk("async rst gpio_dir8", gpio_dir8, 32'h0);
    chk("async rst rdata8", bus8.reg_rdata, 32'h0);
    gpio_in = '0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    rd32(A_DEB, 32'h0);
    rd32(A_DATA_OUT, 32'h0);
    rd32(A_DATA_IN, 32'h0);
    rd8(A_DIR, 32'h0);
    idle(3);

    n_checks++;
    if (exp_q32.size() != 0 || exp_q8.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain pending32=%0d pending8=%0d required=0",
               exp_q32.size(), exp_q8.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
